// File: rtl/signal_debounce_if.sv
// signal_debounce_if: groups the debouncer's level input and its qualified outputs.
//   sig_in     : synchronized input level (driven by the producer / bench)
//   level      : debounced level
//   rise/fall  : single-cycle edge strobes on level
//   glitch_cnt : rejected-transition count (zero unless the counter is built in)
// Modports: master drives sig_in and observes outputs; slave is the debouncer.
interface signal_debounce_if #(
    parameter int unsigned GlitchCntWidth = 8
);
    logic                      sig_in;
    logic                      level;
    logic                      rise;
    logic                      fall;
    logic [GlitchCntWidth-1:0] glitch_cnt;

    modport master (
        output sig_in,
        input  level,
        input  rise,
        input  fall,
        input  glitch_cnt
    );

    modport slave (
        input  sig_in,
        output level,
        output rise,
        output fall,
        output glitch_cnt
    );
endinterface

// File: rtl/signal_debounce.sv
// signal_debounce: qualifies an already-synchronized level. A change is accepted
// only after the new value has been sampled StableCycles+1 consecutive times
// (one entry edge plus StableCycles in-check edges). Any return to the old value
// while checking aborts with no output change and no partial credit.
// Ports:
//   clk  : system clock, posedge
//   rst  : asynchronous active-high reset
//   bus  : signal_debounce_if.slave (sig_in in; level/rise/fall/glitch_cnt out)
// Optional build macro SIGNAL_DEBOUNCE_GLITCH_CNT_EN: when defined, glitch_cnt
// counts aborted checks, saturating, cleared only by rst. When undefined,
// glitch_cnt is tied to zero.
module signal_debounce #(
    parameter int unsigned StableCycles   = 1000,
    parameter bit          ResetLevel     = 1'b0,
    parameter int unsigned GlitchCntWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    signal_debounce_if.slave     bus
);

    localparam int unsigned CntWidth = $clog2(StableCycles + 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        CHECK_HIGH  = 2'b01,
        STABLE_HIGH = 2'b10,
        CHECK_LOW   = 2'b11
    } state_t;

    localparam state_t                ResetState = ResetLevel ? STABLE_HIGH : STABLE_LOW;
    localparam logic [CntWidth-1:0]   CntLast    = CntWidth'(StableCycles - 1);

    state_t              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LOW: begin
                if (bus.sig_in) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = '0;
                end
            end
            CHECK_HIGH: begin
                if (!bus.sig_in) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!bus.sig_in) begin
                    state_d = CHECK_LOW;
                    cnt_d   = '0;
                end
            end
            CHECK_LOW: begin
                if (bus.sig_in) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ResetState;
            cnt_q   <= '0;
            level_q <= ResetLevel;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign bus.level = level_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;

`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
    logic [GlitchCntWidth-1:0] glitch_cnt_q, glitch_cnt_d;
    logic                      glitch_event;

    // An abort is exactly a CHECK state seeing the old value again.
    always_comb begin
        glitch_event = ((state_q == CHECK_HIGH) && !bus.sig_in) ||
                       ((state_q == CHECK_LOW)  &&  bus.sig_in);
        glitch_cnt_d = glitch_cnt_q;
        if (glitch_event && (glitch_cnt_q != '1)) begin
            glitch_cnt_d = glitch_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign bus.glitch_cnt = glitch_cnt_q;
`else
    assign bus.glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_signal_debounce.sv
module tb_signal_debounce;

    localparam int unsigned SC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig = 1'b0;

    always #5 clk = ~clk;

    // Three instances sharing stimulus: ResetLevel 0, ResetLevel 1, narrow glitch counter.
    signal_debounce_if #(.GlitchCntWidth(8)) if_a ();
    signal_debounce_if #(.GlitchCntWidth(8)) if_b ();
    signal_debounce_if #(.GlitchCntWidth(2)) if_c ();

    assign if_a.sig_in = sig;
    assign if_b.sig_in = sig;
    assign if_c.sig_in = sig;

    signal_debounce #(.StableCycles(SC), .ResetLevel(1'b0), .GlitchCntWidth(8)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave));
    signal_debounce #(.StableCycles(SC), .ResetLevel(1'b1), .GlitchCntWidth(8)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave));
    signal_debounce #(.StableCycles(SC), .ResetLevel(1'b0), .GlitchCntWidth(2)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c.slave));

    int tests = 0;
    int fails = 0;

`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
    localparam bit GlitchOn = 1'b1;
`else
    localparam bit GlitchOn = 1'b0;
`endif

    // Reference model: run-length of consecutive samples differing from level.
    bit          rl   [3] = '{1'b0, 1'b1, 1'b0};
    int unsigned gmax [3] = '{255, 255, 3};
    bit          m_lev  [3];
    bit          m_rise [3];
    bit          m_fall [3];
    int unsigned m_run  [3];
    int unsigned m_gl   [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_lev[i]  = rl[i];
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            m_run[i]  = 0;
            m_gl[i]   = 0;
        end
    endtask

    task automatic model_sample(input bit v);
        for (int i = 0; i < 3; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (v != m_lev[i]) begin
                m_run[i]++;
                if (m_run[i] == SC + 1) begin
                    m_lev[i]  = v;
                    m_rise[i] = v;
                    m_fall[i] = !v;
                    m_run[i]  = 0;
                end
            end else begin
                if (m_run[i] > 0 && m_gl[i] < gmax[i]) m_gl[i]++;
                m_run[i] = 0;
            end
        end
    endtask

    task automatic check_one(input string tag, input int i, input logic lev,
                             input logic ri, input logic fa, input logic [7:0] gl);
        logic [7:0] gexp;
        gexp = GlitchOn ? 8'(m_gl[i]) : 8'd0;
        tests++;
        assert (lev === m_lev[i]) else begin
            fails++;
            $error("FAIL %s[%0d].level observed=%b expected=%b t=%0t", tag, i, lev, m_lev[i], $time);
        end
        tests++;
        assert (ri === m_rise[i]) else begin
            fails++;
            $error("FAIL %s[%0d].rise observed=%b expected=%b t=%0t", tag, i, ri, m_rise[i], $time);
        end
        tests++;
        assert (fa === m_fall[i]) else begin
            fails++;
            $error("FAIL %s[%0d].fall observed=%b expected=%b t=%0t", tag, i, fa, m_fall[i], $time);
        end
        tests++;
        assert (!(ri === 1'b1 && fa === 1'b1)) else begin
            fails++;
            $error("FAIL %s[%0d].both_strobes observed=11 expected=not both t=%0t", tag, i, $time);
        end
        tests++;
        assert (gl === gexp) else begin
            fails++;
            $error("FAIL %s[%0d].glitch_cnt observed=%0d expected=%0d t=%0t", tag, i, gl, gexp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_one(tag, 0, if_a.level, if_a.rise, if_a.fall, if_a.glitch_cnt);
        check_one(tag, 1, if_b.level, if_b.rise, if_b.fall, if_b.glitch_cnt);
        check_one(tag, 2, if_c.level, if_c.rise, if_c.fall, 8'(if_c.glitch_cnt));
    endtask

    // Drive at negedge, let one posedge sample it, check at the next negedge.
    task automatic step(input string tag, input bit v);
        sig = v;
        @(posedge clk);
        model_sample(v);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic hold(input string tag, input bit v, input int n);
        for (int k = 0; k < n; k++) step(tag, v);
    endtask

    // Async assert from a negedge; outputs must already be at reset values.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        sig = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        pulse_reset("reset");

        hold("idle_low", 1'b0, 10);

        hold("rise_hold", 1'b1, 10);
        tests++;
        assert (if_a.level === 1'b1) else begin
            fails++;
            $error("FAIL rise_hold.final_level observed=%b expected=1", if_a.level);
        end
        hold("fall_hold", 1'b0, 10);

        for (int b = 0; b < 6; b++) begin
            hold("burst_hi", 1'b1, 3);
            hold("burst_lo", 1'b0, 1);
        end
        hold("burst_settle", 1'b0, 3);

        pulse_reset("reset2");
        hold("mid_check", 1'b1, 2);
        sig = 1'b1;
        pulse_reset("reset_mid_check");
        hold("after_mid_reset", 1'b1, 10);

        hold("boundary_lo_exact", 1'b0, SC + 1);
        hold("boundary_hi_short", 1'b1, SC);
        hold("boundary_lo", 1'b0, 2);

        for (int r = 0; r < 60; r++) begin
            bit          v;
            int unsigned len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * SC + 2);
            hold("random", v, int'(len));
            if ($urandom_range(0, 19) == 0) pulse_reset("random_reset");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
